// File: rtl/ysyx_22050612_mem_arbiter.sv
// Shares one memory port between IFU fetches and LSU loads/stores, one transaction in flight.
// Build option MEMARB_RR_EN: round-robin arbitration on collisions instead of fixed LSU_PRIO.
module ysyx_22050612_mem_arbiter #(
    parameter int AW       = 64,
    parameter int DW       = 64,
    parameter int LSU_PRIO = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ifu_req_valid,
    output logic            ifu_req_ready,
    input  logic [AW-1:0]   ifu_addr,
    output logic            ifu_resp_valid,
    output logic [DW-1:0]   ifu_rdata,
    input  logic            lsu_req_valid,
    output logic            lsu_req_ready,
    input  logic            lsu_wen,
    input  logic [AW-1:0]   lsu_addr,
    input  logic [DW-1:0]   lsu_wdata,
    input  logic [DW/8-1:0] lsu_wmask,
    output logic            lsu_resp_valid,
    output logic [DW-1:0]   lsu_rdata,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic            mem_wen,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wmask,
    input  logic            mem_resp_valid,
    input  logic [DW-1:0]   mem_rdata,
    output logic            busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]      state_reg, state_next;
    logic            owner_lsu_reg;
    logic            wen_reg;
    logic [AW-1:0]   addr_reg;
    logic [DW-1:0]   wdata_reg;
    logic [DW/8-1:0] wmask_reg;
    logic [DW-1:0]   ifu_rdata_reg, lsu_rdata_reg;
    logic            any_req, grant_lsu, accept;

    assign any_req = ifu_req_valid | lsu_req_valid;
    assign accept  = (state_reg == IDLE) && any_req && !rst;

`ifdef MEMARB_RR_EN
    // On a collision the side that did not win last time is served.
    logic last_lsu_reg;
    assign grant_lsu = lsu_req_valid & (~ifu_req_valid | ~last_lsu_reg);

    always_ff @(posedge clk) begin
        if (rst)
            last_lsu_reg <= 1'b0;
        else if (accept)
            last_lsu_reg <= grant_lsu;
    end
`else
    localparam logic LSU_WINS = (LSU_PRIO != 0);
    assign grant_lsu = lsu_req_valid & (~ifu_req_valid | LSU_WINS);
`endif

    assign ifu_req_ready  = accept & ~grant_lsu;
    assign lsu_req_ready  = accept & grant_lsu;
    assign mem_req_valid  = (state_reg == ISSUE);
    assign ifu_resp_valid = (state_reg == RESP) & ~owner_lsu_reg;
    assign lsu_resp_valid = (state_reg == RESP) & owner_lsu_reg;
    assign busy           = (state_reg != IDLE);
    assign mem_wen        = wen_reg;
    assign mem_addr       = addr_reg;
    assign mem_wdata      = wdata_reg;
    assign mem_wmask      = wmask_reg;
    assign ifu_rdata      = ifu_rdata_reg;
    assign lsu_rdata      = lsu_rdata_reg;

    // Responses seen outside WAIT are strays and never move the FSM.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (any_req) state_next = ISSUE;
            ISSUE:   if (mem_req_ready) state_next = WAIT;
            WAIT:    if (mem_resp_valid) state_next = RESP;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            owner_lsu_reg <= 1'b0;
            wen_reg       <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            wmask_reg     <= '0;
            ifu_rdata_reg <= '0;
            lsu_rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                owner_lsu_reg <= grant_lsu;
                wen_reg       <= grant_lsu & lsu_wen;
                addr_reg      <= grant_lsu ? lsu_addr : ifu_addr;
                wdata_reg     <= grant_lsu ? lsu_wdata : '0;
                wmask_reg     <= grant_lsu ? lsu_wmask : '0;
            end
            // Write acknowledgements leave the owner's read data untouched.
            if ((state_reg == WAIT) && mem_resp_valid && !wen_reg) begin
                if (owner_lsu_reg)
                    lsu_rdata_reg <= mem_rdata;
                else
                    ifu_rdata_reg <= mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_22050612_mem_arbiter.sv
// Bench for ysyx_22050612_mem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_ysyx_22050612_mem_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int MW = DW / 8;
    localparam int LSU_PRIO = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [AW-1:0] ifu_addr;
    logic [DW-1:0] ifu_rdata;
    logic          lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wdata, lsu_rdata;
    logic [MW-1:0] lsu_wmask;
    logic          mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [MW-1:0] mem_wmask;

    always #5 clk = ~clk;

    ysyx_22050612_mem_arbiter #(.AW(AW), .DW(DW), .LSU_PRIO(LSU_PRIO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .busy(busy)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Transaction-level reference: one transaction owned by a requester, issued, answered, returned.
    bit            in_flight, issued, got_resp, own_lsu, last_lsu;
    logic          t_wen;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata, exp_ifu_rdata, exp_lsu_rdata;
    logic [MW-1:0] t_wmask;

    // Stimulus knobs and memory responder state
    bit            auto_req, use_fix, mem_wait;
    int            p_ifu, p_lsu, p_ready, p_stray, lo_extra, hi_extra, mem_cnt, lsu_rearm;
    logic [DW-1:0] fix_data;

    // Event log
    int            cyc, ifu_pulses, lsu_pulses, ifu_acc_cyc, ifu_pulse_cyc, n_grants;
    logic [7:0]    grant_log;
    logic          snap_wen;
    logic [AW-1:0] snap_addr;
    logic [DW-1:0] snap_wdata;
    logic [MW-1:0] snap_wmask;

    function automatic bit pick_lsu(bit iv, bit lv);
        if (iv && lv) begin
`ifdef MEMARB_RR_EN
            return !last_lsu;
`else
            return LSU_PRIO != 0;
`endif
        end
        return lv;
    endfunction

    task automatic tick();
        bit e_ir, e_lr, lw, hs;
        @(negedge clk);
        cyc++;
        lw   = pick_lsu(ifu_req_valid, lsu_req_valid);
        e_ir = !rst && !in_flight && ifu_req_valid && !lw;
        e_lr = !rst && !in_flight && lsu_req_valid && lw;
        hs   = in_flight && !issued && mem_req_ready;
        check("ifu_req_ready", ifu_req_ready, e_ir);
        check("lsu_req_ready", lsu_req_ready, e_lr);
        check("busy", busy, in_flight);
        check("mem_req_valid", mem_req_valid, in_flight && !issued);
        if (in_flight && !issued) begin
            check("mem_wen", mem_wen, t_wen);
            check("mem_addr", mem_addr, t_addr);
            check("mem_wmask", mem_wmask, t_wmask);
            if (t_wen) check("mem_wdata", mem_wdata, t_wdata);
        end
        check("ifu_resp_valid", ifu_resp_valid, in_flight && got_resp && !own_lsu);
        check("lsu_resp_valid", lsu_resp_valid, in_flight && got_resp && own_lsu);
        check("ifu_rdata", ifu_rdata, exp_ifu_rdata);
        check("lsu_rdata", lsu_rdata, exp_lsu_rdata);
        if (ifu_req_ready) ifu_acc_cyc = cyc;
        if (ifu_resp_valid) begin ifu_pulses++; ifu_pulse_cyc = cyc; end
        if (lsu_resp_valid) lsu_pulses++;
        if (mem_req_valid) begin
            snap_wen = mem_wen; snap_addr = mem_addr; snap_wdata = mem_wdata; snap_wmask = mem_wmask;
        end
        if (e_ir || e_lr) begin
            grant_log = {grant_log[6:0], e_lr};
            n_grants++;
        end

        if (rst) begin
            in_flight = 0; issued = 0; got_resp = 0; last_lsu = 0;
            exp_ifu_rdata = '0; exp_lsu_rdata = '0;
        end else if (e_ir || e_lr) begin
            in_flight = 1; issued = 0; got_resp = 0; own_lsu = e_lr; last_lsu = e_lr;
            t_wen   = e_lr ? lsu_wen : 1'b0;
            t_addr  = e_lr ? lsu_addr : ifu_addr;
            t_wdata = lsu_wdata;
            t_wmask = e_lr ? lsu_wmask : '0;
        end else if (in_flight) begin
            if (got_resp) in_flight = 0;
            else if (!issued) issued = mem_req_ready;
            else if (mem_resp_valid) begin
                got_resp = 1;
                if (!t_wen) begin
                    if (own_lsu) exp_lsu_rdata = mem_rdata;
                    else exp_ifu_rdata = mem_rdata;
                end
            end
        end

        @(posedge clk);
        #1;
        if (e_ir) ifu_req_valid = 1'b0;
        if (e_lr) lsu_req_valid = 1'b0;
        if (!ifu_req_valid) begin
            ifu_addr = {$urandom, $urandom};
            if (auto_req && $urandom_range(99) < p_ifu) ifu_req_valid = 1'b1;
        end
        if (!lsu_req_valid) begin
            lsu_wen   = 1'($urandom_range(1));
            lsu_addr  = {$urandom, $urandom};
            lsu_wdata = {$urandom, $urandom};
            lsu_wmask = ($urandom_range(3) == 0) ? '0 : MW'($urandom);
            if (auto_req && $urandom_range(99) < p_lsu) lsu_req_valid = 1'b1;
            if (e_lr && lsu_rearm > 0) begin lsu_req_valid = 1'b1; lsu_rearm--; end
        end
        mem_resp_valid = 1'b0;
        if (hs) begin mem_wait = 1; mem_cnt = $urandom_range(hi_extra, lo_extra); end
        if (mem_wait) begin
            if (mem_cnt == 0) begin
                mem_resp_valid = 1'b1;
                mem_rdata = use_fix ? fix_data : {$urandom, $urandom};
                mem_wait = 0;
            end else mem_cnt--;
        end else if (!(in_flight && issued) && $urandom_range(99) < p_stray) begin
            mem_resp_valid = 1'b1;
            mem_rdata = {$urandom, $urandom};
        end
        mem_req_ready = $urandom_range(99) < p_ready;
        if (auto_req) rst = ($urandom_range(249) == 0);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (!in_flight && !ifu_req_valid && !lsu_req_valid) break;
            tick();
        end
        check(tag, {in_flight, ifu_req_valid, lsu_req_valid}, 0);
    endtask

    initial begin
        int c0, p0, n;
        rst = 1; ifu_req_valid = 0; ifu_addr = '0; lsu_req_valid = 0; lsu_wen = 0;
        lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0; mem_req_ready = 1; mem_resp_valid = 0; mem_rdata = '0;
        auto_req = 0; use_fix = 0; p_ifu = 0; p_lsu = 0; p_ready = 100; p_stray = 0;
        lo_extra = 0; hi_extra = 0; lsu_rearm = 0; mem_wait = 0; mem_cnt = 0; fix_data = '0;
        repeat (2) @(posedge clk);
        #1;
        tick();
        rst = 0;
        check("reset mem_addr", mem_addr, 0);
        check("reset mem_wdata", mem_wdata, 0);
        check("reset mem_wmask", mem_wmask, 0);
        check("reset mem_wen", mem_wen, 0);
        check("reset busy", busy, 0);

        // IFU fetch with 1-cycle memory
        use_fix = 1; fix_data = 64'h0000_0013_0000_0297;
        ifu_req_valid = 1; ifu_addr = 64'h8000_0000;
        c0 = cyc; p0 = lsu_pulses;
        repeat (6) tick();
        check("t1 accept cycle", ifu_acc_cyc, c0 + 1);
        check("t1 latency", ifu_pulse_cyc - ifu_acc_cyc, 3);
        check("t1 ifu_rdata", ifu_rdata, 64'h0000_0013_0000_0297);
        check("t1 no lsu resp", lsu_pulses, p0);
        use_fix = 0;

        // LSU store
        lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 64'h8000_0104;
        lsu_wdata = 64'h0000_00AB_0000_0000; lsu_wmask = 8'h10;
        p0 = lsu_pulses;
        repeat (6) tick();
        check("t2 mem_addr", snap_addr, 64'h8000_0104);
        check("t2 mem_wdata", snap_wdata, 64'h0000_00AB_0000_0000);
        check("t2 mem_wmask", snap_wmask, 8'h10);
        check("t2 mem_wen", snap_wen, 1);
        check("t2 one pulse", lsu_pulses - p0, 1);
        check("t2 lsu_rdata kept", lsu_rdata, 0);

        // Collision after reset, LSU re-requesting immediately once
        rst = 1; tick(); rst = 0;
        grant_log = '0; n_grants = 0; lsu_rearm = 1;
        ifu_req_valid = 1; ifu_addr = 64'h8000_0010;
        lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 64'h8000_0200;
        repeat (16) tick();
        check("t3 grants", n_grants, 3);
`ifdef MEMARB_RR_EN
        check("t3 order", grant_log[2:0], 3'b101);
`else
        check("t3 order", grant_log[2:0], 3'b110);
`endif
        drain("t3 drain");

        // Memory stalls requests for 5 cycles while the other side waits
        p_ready = 0;
        ifu_req_valid = 1; ifu_addr = 64'h8000_0020;
        tick();
        lsu_req_valid = 1; lsu_wen = 1;
        repeat (5) tick();
        check("t4 busy", busy, 1);
        check("t4 mem_req_valid", mem_req_valid, 1);
        check("t4 mem_addr", mem_addr, 64'h8000_0020);
        p_ready = 100;
        drain("t4 drain");

        // Reset during WAIT with the response landing right after
        lo_extra = 1; hi_extra = 1;
        ifu_req_valid = 1; ifu_addr = 64'h8000_0040;
        n = 0;
        while (!(in_flight && issued) && n < 10) begin tick(); n++; end
        check("t5 reached wait", in_flight && issued, 1);
        p0 = ifu_pulses;
        rst = 1; tick(); rst = 0;
        check("t5 busy", busy, 0);
        check("t5 mem_req_valid", mem_req_valid, 0);
        check("t5 mem_addr", mem_addr, 0);
        check("t5 ifu_rdata", ifu_rdata, 0);
        repeat (3) tick();
        check("t5 no pulse", ifu_pulses, p0);
        lo_extra = 0; hi_extra = 0;

        // Stray responses while idle
        p_stray = 100; p0 = ifu_pulses + lsu_pulses;
        repeat (5) tick();
        check("t6 no pulse", ifu_pulses + lsu_pulses, p0);
        check("t6 busy", busy, 0);

        // Random traffic
        auto_req = 1; p_ifu = 35; p_lsu = 35; p_ready = 70; p_stray = 15; hi_extra = 3;
        repeat (3000) tick();
        auto_req = 0; rst = 0; p_stray = 0;
        drain("random drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
